// File: rtl/router_ingress_arb_if.sv
// Ingress bundle between the upstream packet sources, the arbiter and the router input port.
// The master side drives the sources and router ready; the slave side is the arbiter.
interface router_ingress_arb_if #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 10,
  parameter int CNT_W      = 16
);
  logic [NUM_SRC-1:0]                 src_valid_i;
  logic [NUM_SRC-1:0][DATA_WIDTH-1:0] src_data_i;
  logic [NUM_SRC-1:0]                 src_ready_o;
  logic                               valid_o;
  logic [DATA_WIDTH-1:0]              data_o;
  logic                               ready_i;
  logic [CNT_W-1:0]                   pkt_cnt_o;

  modport master (
    output src_valid_i, src_data_i, ready_i,
    input  src_ready_o, valid_o, data_o, pkt_cnt_o
  );

  modport slave (
    input  src_valid_i, src_data_i, ready_i,
    output src_ready_o, valid_o, data_o, pkt_cnt_o
  );
endinterface

// File: rtl/router_ingress_arb.sv
// Round-robin merge of NUM_SRC packet sources onto the router's single valid/ready port.
// The winner is captured in one output register so the router sees flops only.
module router_ingress_arb #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 10,
  parameter int CNT_W      = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  router_ingress_arb_if.slave bus
);
  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_SRC - 1);

  logic [IDX_W-1:0]      last_q;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [CNT_W-1:0]      cnt_q;

  logic [NUM_SRC-1:0]    grant;
  logic [IDX_W-1:0]      grant_idx;
  logic [NUM_SRC-1:0]    src_ready;
  logic                  load_en;
  logic                  take;
  logic                  drain;

  // Search starts just after the last winner, wrapping modulo NUM_SRC.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] idx;
    logic             found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    idx       = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      cand = int'(last_q) + i;
      if (cand >= NUM_SRC) cand = cand - NUM_SRC;
      idx = IDX_W'(cand);
      if (!found && bus.src_valid_i[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        found      = 1'b1;
      end
    end
  end

  assign load_en   = !valid_q || bus.ready_i;
  // Reset gating keeps any source from seeing a handshake while the block is held in reset.
  assign src_ready = grant & {NUM_SRC{load_en && rst_ni}};
  assign take      = |src_ready;
  assign drain     = valid_q && bus.ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
    end else begin
      if (drain) cnt_q <= cnt_q + 1'b1;
      if (take) begin
        valid_q <= 1'b1;
        data_q  <= bus.src_data_i[grant_idx];
        last_q  <= grant_idx;
      end else if (drain) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.src_ready_o = src_ready;
  assign bus.valid_o     = valid_q;
  assign bus.data_o      = data_q;
  assign bus.pkt_cnt_o   = cnt_q;

  a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(src_ready));

  // A stalled output must present the same packet on the next cycle.
  a_stall_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_q && !bus.ready_i) |=> (valid_q && $stable(data_q)));

  a_no_ready_stall: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_q && !bus.ready_i) |-> (src_ready == '0));
endmodule

// File: tb/tb_router_ingress_arb.sv
// Scoreboard bench for router_ingress_arb: a cycle model queues expected packets at grant
// time and pops them when the router side accepts; CNT_W=4 so the counter wrap is reachable.
module tb_router_ingress_arb;
  localparam int NS = 4;
  localparam int DW = 10;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  router_ingress_arb_if #(.NUM_SRC(NS), .DATA_WIDTH(DW), .CNT_W(CW)) bus ();

  router_ingress_arb #(.NUM_SRC(NS), .DATA_WIDTH(DW), .CNT_W(CW)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // stimulus state
  int                      rem [NS];
  logic [NS-1:0][DW-1:0]   sd;
  logic                    rdy;

  // reference model
  logic                    m_valid;
  logic [DW-1:0]           m_data;
  int                      m_last;
  logic [CW-1:0]           m_cnt;
  logic [DW-1:0]           exp_q [$];

  // observations
  logic [NS-1:0]           obs_rdy;
  logic                    obs_valid;
  logic [DW-1:0]           obs_data;
  logic [1:0]              del_src [$];
  int                      n_del;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < NS; k++) bus.src_valid_i[k] = (rem[k] > 0);
    bus.src_data_i = sd;
    bus.ready_i    = rdy;
  endtask

  function automatic int model_grant();
    int idx;
    for (int i = 1; i <= NS; i++) begin
      idx = (m_last + i) % NS;
      if (rem[idx] > 0) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_last  = NS - 1;
    m_cnt   = '0;
    exp_q.delete();
  endtask

  // One clock: check at the falling edge, advance the model, update sources after the rise.
  task automatic cycle();
    int            g;
    logic [NS-1:0] er;
    logic [DW-1:0] e;
    @(negedge clk);
    g  = model_grant();
    er = '0;
    if (g >= 0 && (!m_valid || rdy)) er[g] = 1'b1;
    obs_rdy   = bus.src_ready_o;
    obs_valid = bus.valid_o;
    obs_data  = bus.data_o;
    chk("src_ready", 32'(bus.src_ready_o), 32'(er));
    chk("valid", 32'(bus.valid_o), 32'(m_valid));
    if (m_valid) chk("data", 32'(bus.data_o), 32'(m_data));
    chk("cnt", 32'(bus.pkt_cnt_o), 32'(m_cnt));
    if (bus.valid_o && rdy) begin
      n_del++;
      if (exp_q.size() == 0) chk("spurious_pkt", 32'(bus.data_o), 32'h3ff_0000);
      else begin
        e = exp_q.pop_front();
        chk("deliver", 32'(bus.data_o), 32'(e));
      end
      del_src.push_back(bus.data_o[DW-1:DW-2]);
    end
    if (m_valid && rdy) m_cnt = m_cnt + 1'b1;
    if (er != '0) begin
      exp_q.push_back(sd[g]);
      m_data  = sd[g];
      m_valid = 1'b1;
      m_last  = g;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    if (er != '0) begin
      rem[g]--;
      sd[g] = {g[1:0], 8'($urandom)};
    end
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int k = 0; k < NS; k++) rem[k] = 0;
    rdy = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(bus.valid_o), 32'h0);
    chk("rst_data", 32'(bus.data_o), 32'h0);
    chk("rst_cnt", 32'(bus.pkt_cnt_o), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    del_src.delete();
    n_del = 0;
  endtask

  task automatic chk_order(input string tag, input int exp_ord [$]);
    chk({tag, "_len"}, 32'(del_src.size()), 32'(exp_ord.size()));
    for (int i = 0; i < exp_ord.size(); i++)
      if (i < del_src.size()) chk(tag, 32'(del_src[i]), 32'(exp_ord[i]));
  endtask

  initial begin
    logic [DW-1:0] d1;
    int            prev;
    for (int k = 0; k < NS; k++) sd[k] = {k[1:0], 8'($urandom)};
    model_reset();
    n_del = 0;
    do_reset();

    // single source, same-cycle ready, one-cycle latency
    sd[2] = 10'h2A5; rem[2] = 1; rdy = 1'b1; drive();
    cycle();
    chk("t1_ready", 32'(obs_rdy), 32'b0100);
    cycle();
    chk("t1_valid", 32'(obs_valid), 32'h1);
    chk("t1_data", 32'(obs_data), 32'h2A5);
    chk("t1_cnt", 32'(bus.pkt_cnt_o), 32'h1);

    // all sources continuously valid: full throughput, rotating grants
    do_reset();
    for (int k = 0; k < NS; k++) rem[k] = 2;
    rdy = 1'b1; drive();
    for (int c = 0; c < 8; c++) begin
      cycle();
      chk("t2_tput", 32'($countones(obs_rdy)), 32'h1);
    end
    cycle();
    chk_order("t2_order", '{0, 1, 2, 3, 0, 1, 2, 3});
    chk("t2_cnt", 32'(bus.pkt_cnt_o), 32'h8);

    // backpressure holds the output and blocks all sources
    do_reset();
    rem[1] = 1; rdy = 1'b0; d1 = sd[1]; drive();
    cycle();
    rem[0] = 1; rem[2] = 1; drive();
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk("t3_ready", 32'(obs_rdy), 32'h0);
      chk("t3_valid", 32'(obs_valid), 32'h1);
      chk("t3_data", 32'(obs_data), 32'(d1));
    end
    rdy = 1'b1; drive();
    repeat (3) cycle();
    chk_order("t3_order", '{1, 2, 0});

    // toggling ready: nothing lost or duplicated
    do_reset();
    rem[0] = 2; rem[3] = 2;
    for (int c = 0; c < 20 && n_del < 4; c++) begin
      rdy = (c % 2 == 0);
      drive();
      cycle();
    end
    chk("t4_count", 32'(n_del), 32'h4);
    chk_order("t4_order", '{0, 3, 0, 3});
    chk("t4_cnt", 32'(bus.pkt_cnt_o), 32'h4);

    // asynchronous reset while a packet is stalled at the output
    rem[1] = 1; rdy = 1'b1; drive();
    cycle();
    rdy = 1'b0; rem[0] = 1; rem[2] = 1; drive();
    cycle();
    chk("t5_pre_valid", 32'(bus.valid_o), 32'h1);
    chk("t5_pre_cnt", 32'(bus.pkt_cnt_o), 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_valid", 32'(bus.valid_o), 32'h0);
    chk("t5_async_cnt", 32'(bus.pkt_cnt_o), 32'h0);
    chk("t5_rst_ready", 32'(bus.src_ready_o), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    rdy = 1'b1; drive();
    cycle();
    chk("t5_first", 32'(obs_rdy), 32'b0001);
    repeat (2) cycle();
    chk("t5_sb_empty", 32'(exp_q.size()), 32'h0);

    // counter wrap at 2^CNT_W
    do_reset();
    rem[0] = 40; rdy = 1'b1; drive();
    for (int c = 0; c < 40 && n_del < 17; c++) begin
      prev = n_del;
      cycle();
      if (n_del != prev) begin
        if (n_del == 15) chk("wrap15", 32'(bus.pkt_cnt_o), 32'd15);
        if (n_del == 16) chk("wrap16", 32'(bus.pkt_cnt_o), 32'd0);
        if (n_del == 17) chk("wrap17", 32'(bus.pkt_cnt_o), 32'd1);
      end
    end
    chk("wrap_reached", 32'(n_del), 32'd17);
    rem[0] = 0; drive();
    repeat (2) cycle();
    chk("sb_empty", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
